// File: rtl/alu_iter_pkg.sv
// Shared types and constants for the iterative ALU: opcodes, flag positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SHL = 4'b0101,
    OP_SHR = 4'b0110,
    OP_SRA = 4'b0111,
    OP_MUL = 4'b1000,
    OP_DIV = 4'b1001,
    OP_MOD = 4'b1010
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } alu_state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Issue/result bundle between the register-read stage, the ALU and write-back.
interface alu_iter_if #(parameter int N = 4);
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [3:0]   opcode_i;
  logic         valid_o;
  logic [N-1:0] result_o;
  logic [3:0]   ALUFlags;

  modport master (
    output valid_i, a_i, b_i, opcode_i,
    input  ready_o, valid_o, result_o, ALUFlags
  );

  modport slave (
    input  valid_i, a_i, b_i, opcode_i,
    output ready_o, valid_o, result_o, ALUFlags
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// N-step shift-add multiplier and restoring divider sharing one {hi,lo} register pair.
// Outputs present the value after the current step so the top can register it on the final edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           run_i,
  input  logic           mul_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o,
  output logic [N-1:0]   quot_o,
  output logic [N-1:0]   rem_o,
  output logic           dbz_o
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  opnd_q;
  logic          mul_q;
  logic          dbz_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    sum;
  logic [N:0]    r_sh;
  logic [N+1:0]  diff;

  // Multiply: {hi,lo} starts as {0,b}; add a into hi when lo[0] is set, then shift right.
  // Divide: {hi,lo} starts as {0,a}; shift left into hi, subtract b when it fits.
  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    r_sh = {hi_q, lo_q[N-1]};
    diff = {1'b0, r_sh} - {2'b00, opnd_q};
    if (mul_q) begin
      hi_d = sum[N:1];
      lo_d = {sum[0], lo_q[N-1:1]};
    end else if (!diff[N+1]) begin
      hi_d = diff[N-1:0];
      lo_d = {lo_q[N-2:0], 1'b1};
    end else begin
      hi_d = r_sh[N-1:0];
      lo_d = {lo_q[N-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      hi_q   <= '0;
      lo_q   <= mul_i ? b_i : a_i;
      opnd_q <= mul_i ? a_i : b_i;
      mul_q  <= mul_i;
      dbz_q  <= !mul_i && (b_i == '0);
      cnt_q  <= CW'(N - 1);
    end else if (run_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  // A zero divisor needs no special path: the quotient fills with ones and a shifts into the remainder.
  assign done_o = run_i && (cnt_q == '0);
  assign prod_o = {hi_d, lo_d};
  assign quot_o = lo_d;
  assign rem_o  = hi_d;
  assign dbz_o  = dbz_q;

endmodule

// File: rtl/alu_iter.sv
// Handshaked N-bit ALU: single-cycle arithmetic/logic/shift, iterative MUL/DIV/MOD,
// registered result and NZCV flags with a one-cycle valid_o pulse.
module alu_iter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_iter_if.slave  bus
);

  alu_state_t     state_q, state_d;
  logic [N-1:0]   res_q;
  logic [3:0]     flags_q;
  logic           valid_q;
  logic [3:0]     op_q;

  logic           ready;
  logic           accept;
  logic           iter_op;
  logic           start;
  logic           md_done;
  logic [2*N-1:0] md_prod;
  logic [N-1:0]   md_quot;
  logic [N-1:0]   md_rem;
  logic           md_dbz;

  logic [N-1:0]   sc_res;
  logic           sc_c, sc_v;
  logic [N-1:0]   it_res;
  logic           it_c, it_v;
  logic [N:0]     add_w, sub_w;
  logic           big_sh;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = RUN;
      RUN:     if (md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready   = (state_q == IDLE);
    iter_op = is_iter_op(bus.opcode_i);
    accept  = bus.valid_i && ready;
    start   = accept && iter_op;
  end

  alu_muldiv_iter #(.N(N)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .run_i   (state_q == RUN),
    .mul_i   (bus.opcode_i == OP_MUL),
    .a_i     (bus.a_i),
    .b_i     (bus.b_i),
    .done_o  (md_done),
    .prod_o  (md_prod),
    .quot_o  (md_quot),
    .rem_o   (md_rem),
    .dbz_o   (md_dbz)
  );

  always_comb begin
    add_w  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    sub_w  = {1'b0, bus.a_i} - {1'b0, bus.b_i};
    big_sh = 32'(bus.b_i) >= N;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.opcode_i)
      OP_ADD: begin
        sc_res = add_w[N-1:0];
        sc_c   = add_w[N];
        sc_v   = (bus.a_i[N-1] == bus.b_i[N-1]) && (add_w[N-1] != bus.a_i[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[N-1:0];
        sc_c   = !sub_w[N];
        sc_v   = (bus.a_i[N-1] != bus.b_i[N-1]) && (sub_w[N-1] != bus.a_i[N-1]);
      end
      OP_AND: sc_res = bus.a_i & bus.b_i;
      OP_OR:  sc_res = bus.a_i | bus.b_i;
      OP_XOR: sc_res = bus.a_i ^ bus.b_i;
      OP_SHL: sc_res = big_sh ? '0 : bus.a_i << bus.b_i;
      OP_SHR: sc_res = big_sh ? '0 : bus.a_i >> bus.b_i;
      OP_SRA: sc_res = big_sh ? {N{bus.a_i[N-1]}} : N'($signed(bus.a_i) >>> bus.b_i);
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    it_res = md_prod[N-1:0];
    it_c   = 1'b0;
    it_v   = md_dbz;
    case (op_q)
      OP_MUL: begin
        it_c = |md_prod[2*N-1:N];
        it_v = 1'b0;
      end
      OP_DIV:  it_res = md_quot;
      default: it_res = md_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (start) op_q <= bus.opcode_i;
      if (md_done) begin
        res_q           <= it_res;
        flags_q[FLAG_N] <= it_res[N-1];
        flags_q[FLAG_Z] <= (it_res == '0);
        flags_q[FLAG_C] <= it_c;
        flags_q[FLAG_V] <= it_v;
        valid_q         <= 1'b1;
      end else if (accept && !iter_op) begin
        res_q           <= sc_res;
        flags_q[FLAG_N] <= sc_res[N-1];
        flags_q[FLAG_Z] <= (sc_res == '0);
        flags_q[FLAG_C] <= sc_c;
        flags_q[FLAG_V] <= sc_v;
        valid_q         <= 1'b1;
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = res_q;
  assign bus.ALUFlags = flags_q;

endmodule
